riv_front_pipe: RTL and testbench

- Three-stage in-order RV64I front end: IF (PC plus writable instruction memory), ID (decode, 32x64 register file, write scoreboard), EX (ALU, branch/jump resolution).
- Sits ahead of the memory and write-back stages. It consumes the write-back register port and a memory-stage ready signal, and emits one EX result bundle per accepted instruction.

---
 rtl/riv_front_pipe.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_riv_front_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/riv_front_pipe.sv
`default_nettype none
// ============================================================================
// Module   : riv_front_pipe
// Purpose  : RV64I IF/ID/EX front end with writable imem, scoreboard and ALU
// Revision : 1.0  initial release
// ============================================================================
module riv_front_pipe #(
    parameter int IM_DEPTH = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  i_wen,
    input  logic [$clog2(IM_DEPTH)-1:0] i_waddr,
    input  logic [31:0]                 i_wdata,
    input  logic                        i_mem_ready,
    input  logic [4:0]                  i_wb_wr_reg_addr,
    input  logic [63:0]                 i_wb_wr_reg_data,
    input  logic                        i_wb_wr_reg_en,
    output logic                        o_ex_valid,
    output logic [63:0]                 o_ex_result,
    output logic [63:0]                 o_ex_store_data,
    output logic [4:0]                  o_ex_rd_addr,
    output logic                        o_ex_rd_we,
    output logic                        o_ex_is_load,
    output logic                        o_ex_is_store,
    output logic [2:0]                  o_ex_funct3,
    output logic                        o_ex_branch_taken,
    output logic                        o_ex_jump_taken,
    output logic [63:0]                 o_ex_target,
    output logic                        o_illegal
);
    localparam int         c_AW        = $clog2(IM_DEPTH);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_OP32   = 7'b0111011;

    logic [31:0] r_imem [IM_DEPTH];
    logic [63:0] r_rf   [32];
    logic [31:0] r_sb, w_sb_next;

    logic [63:0] r_pc;
    logic        r_fd_valid;
    logic [31:0] r_fd_instr;
    logic [63:0] r_fd_pc;

    logic        r_de_valid, r_de_rd_we, r_de_f7b5;
    logic [6:0]  r_de_opc;
    logic [2:0]  r_de_f3;
    logic [4:0]  r_de_rd;
    logic [63:0] r_de_pc, r_de_rs1, r_de_rs2, r_de_imm;

    logic        r_out_valid, r_out_rd_we, r_out_is_load, r_out_is_store, r_illegal;
    logic [63:0] r_out_result, r_out_store_data;
    logic [4:0]  r_out_rd;
    logic [2:0]  r_out_f3;

    logic [31:0] w_if_instr;
    logic [6:0]  w_id_opc;
    logic [4:0]  w_id_rs1, w_id_rs2, w_id_rd;
    logic        w_id_legal, w_id_use1, w_id_use2, w_id_wr, w_id_rd_we;
    logic [63:0] w_id_imm, w_id_rs1_val, w_id_rs2_val;
    logic        w_busy1, w_busy2, w_hazard, w_issue, w_drop;

    logic        w_is_w, w_is_reg, w_sub, w_cond, w_br_taken, w_jump, w_redirect;
    logic [63:0] w_b, w_alu, w_result, w_target;
    logic [31:0] w_alu32;

    // ---------------- instruction memory ----------------
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_wen[b]) r_imem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    assign w_if_instr = r_imem[r_pc[c_AW+1:2]];

    // ---------------- decode ----------------
    assign w_id_opc = r_fd_instr[6:0];
    assign w_id_rd  = r_fd_instr[11:7];
    assign w_id_rs1 = r_fd_instr[19:15];
    assign w_id_rs2 = r_fd_instr[24:20];

    always_comb begin
        w_id_legal = 1'b0;
        w_id_use1  = 1'b0;
        w_id_use2  = 1'b0;
        w_id_wr    = 1'b0;
        w_id_imm   = '0;
        case (w_id_opc)
            c_OP_LUI, c_OP_AUIPC: begin
                w_id_legal = 1'b1; w_id_wr = 1'b1;
                w_id_imm   = {{32{r_fd_instr[31]}}, r_fd_instr[31:12], 12'b0};
            end
            c_OP_JAL: begin
                w_id_legal = 1'b1; w_id_wr = 1'b1;
                w_id_imm   = {{43{r_fd_instr[31]}}, r_fd_instr[31], r_fd_instr[19:12],
                              r_fd_instr[20], r_fd_instr[30:21], 1'b0};
            end
            c_OP_JALR, c_OP_LOAD, c_OP_IMM, c_OP_IMM32: begin
                w_id_legal = 1'b1; w_id_wr = 1'b1; w_id_use1 = 1'b1;
                w_id_imm   = {{52{r_fd_instr[31]}}, r_fd_instr[31:20]};
            end
            c_OP_BRANCH: begin
                w_id_legal = 1'b1; w_id_use1 = 1'b1; w_id_use2 = 1'b1;
                w_id_imm   = {{51{r_fd_instr[31]}}, r_fd_instr[31], r_fd_instr[7],
                              r_fd_instr[30:25], r_fd_instr[11:8], 1'b0};
            end
            c_OP_STORE: begin
                w_id_legal = 1'b1; w_id_use1 = 1'b1; w_id_use2 = 1'b1;
                w_id_imm   = {{52{r_fd_instr[31]}}, r_fd_instr[31:25], r_fd_instr[11:7]};
            end
            c_OP_OP, c_OP_OP32: begin
                w_id_legal = 1'b1; w_id_wr = 1'b1; w_id_use1 = 1'b1; w_id_use2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_id_rd_we = w_id_wr && (w_id_rd != 5'd0);

    // Write-first: a WB write this cycle bypasses the array
    assign w_id_rs1_val = (w_id_rs1 == 5'd0) ? 64'd0 :
                          (i_wb_wr_reg_en && i_wb_wr_reg_addr == w_id_rs1) ? i_wb_wr_reg_data :
                          r_rf[w_id_rs1];
    assign w_id_rs2_val = (w_id_rs2 == 5'd0) ? 64'd0 :
                          (i_wb_wr_reg_en && i_wb_wr_reg_addr == w_id_rs2) ? i_wb_wr_reg_data :
                          r_rf[w_id_rs2];

    always_ff @(posedge clk) begin
        if (i_wb_wr_reg_en && i_wb_wr_reg_addr != 5'd0)
            r_rf[i_wb_wr_reg_addr] <= i_wb_wr_reg_data;
    end

    assign w_busy1  = w_id_use1 && (w_id_rs1 != 5'd0) && r_sb[w_id_rs1] &&
                      !(i_wb_wr_reg_en && i_wb_wr_reg_addr == w_id_rs1);
    assign w_busy2  = w_id_use2 && (w_id_rs2 != 5'd0) && r_sb[w_id_rs2] &&
                      !(i_wb_wr_reg_en && i_wb_wr_reg_addr == w_id_rs2);
    assign w_hazard = r_fd_valid && w_id_legal && (w_busy1 || w_busy2);
    assign w_issue  = i_mem_ready && r_fd_valid && w_id_legal && !w_hazard && !w_redirect;
    assign w_drop   = i_mem_ready && r_fd_valid && !w_id_legal && !w_redirect;

    // Set is applied after clear so an issue wins over a same-register WB
    always_comb begin
        w_sb_next = r_sb;
        if (i_wb_wr_reg_en) w_sb_next[i_wb_wr_reg_addr] = 1'b0;
        if (w_issue && w_id_rd_we) w_sb_next[w_id_rd] = 1'b1;
        w_sb_next[0] = 1'b0;
    end

    // ---------------- execute ----------------
    assign w_is_w   = (r_de_opc == c_OP_IMM32) || (r_de_opc == c_OP_OP32);
    assign w_is_reg = (r_de_opc == c_OP_OP)    || (r_de_opc == c_OP_OP32);
    assign w_b      = w_is_reg ? r_de_rs2 : r_de_imm;
    assign w_sub    = w_is_reg && r_de_f7b5;

    always_comb begin
        case (r_de_f3)
            3'b000:  w_alu = w_sub ? r_de_rs1 - w_b : r_de_rs1 + w_b;
            3'b001:  w_alu = r_de_rs1 << w_b[5:0];
            3'b010:  w_alu = {63'b0, $signed(r_de_rs1) < $signed(w_b)};
            3'b011:  w_alu = {63'b0, r_de_rs1 < w_b};
            3'b100:  w_alu = r_de_rs1 ^ w_b;
            3'b101:  w_alu = r_de_f7b5 ? $signed(r_de_rs1) >>> w_b[5:0] : r_de_rs1 >> w_b[5:0];
            3'b110:  w_alu = r_de_rs1 | w_b;
            default: w_alu = r_de_rs1 & w_b;
        endcase
    end

    always_comb begin
        case (r_de_f3)
            3'b000:  w_alu32 = w_sub ? r_de_rs1[31:0] - w_b[31:0] : r_de_rs1[31:0] + w_b[31:0];
            3'b001:  w_alu32 = r_de_rs1[31:0] << w_b[4:0];
            3'b101:  w_alu32 = r_de_f7b5 ? $signed(r_de_rs1[31:0]) >>> w_b[4:0]
                                         : r_de_rs1[31:0] >> w_b[4:0];
            default: w_alu32 = r_de_rs1[31:0] + w_b[31:0];
        endcase
    end

    always_comb begin
        case (r_de_opc)
            c_OP_LUI:               w_result = r_de_imm;
            c_OP_AUIPC:             w_result = r_de_pc + r_de_imm;
            c_OP_JAL, c_OP_JALR:    w_result = r_de_pc + 64'd4;
            c_OP_LOAD, c_OP_STORE:  w_result = r_de_rs1 + r_de_imm;
            c_OP_IMM, c_OP_OP:      w_result = w_alu;
            c_OP_IMM32, c_OP_OP32:  w_result = {{32{w_alu32[31]}}, w_alu32};
            default:                w_result = 64'd0;
        endcase
    end

    always_comb begin
        case (r_de_f3)
            3'b000:  w_cond = (r_de_rs1 == r_de_rs2);
            3'b001:  w_cond = (r_de_rs1 != r_de_rs2);
            3'b100:  w_cond = ($signed(r_de_rs1) <  $signed(r_de_rs2));
            3'b101:  w_cond = ($signed(r_de_rs1) >= $signed(r_de_rs2));
            3'b110:  w_cond = (r_de_rs1 <  r_de_rs2);
            3'b111:  w_cond = (r_de_rs1 >= r_de_rs2);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_target   = (r_de_opc == c_OP_JALR) ? ((r_de_rs1 + r_de_imm) & ~64'd1)
                                                : (r_de_pc + r_de_imm);
    assign w_br_taken = r_de_valid && (r_de_opc == c_OP_BRANCH) && w_cond;
    assign w_jump     = r_de_valid && ((r_de_opc == c_OP_JAL) || (r_de_opc == c_OP_JALR));
    assign w_redirect = i_mem_ready && (w_br_taken || w_jump);

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc             <= '0;
            r_sb             <= '0;
            r_fd_valid       <= 1'b0;
            r_fd_instr       <= '0;
            r_fd_pc          <= '0;
            r_de_valid       <= 1'b0;
            r_de_rd_we       <= 1'b0;
            r_de_f7b5        <= 1'b0;
            r_de_opc         <= '0;
            r_de_f3          <= '0;
            r_de_rd          <= '0;
            r_de_pc          <= '0;
            r_de_rs1         <= '0;
            r_de_rs2         <= '0;
            r_de_imm         <= '0;
            r_out_valid      <= 1'b0;
            r_out_rd_we      <= 1'b0;
            r_out_is_load    <= 1'b0;
            r_out_is_store   <= 1'b0;
            r_out_result     <= '0;
            r_out_store_data <= '0;
            r_out_rd         <= '0;
            r_out_f3         <= '0;
            r_illegal        <= 1'b0;
        end else begin
            r_sb      <= w_sb_next;
            r_illegal <= w_drop;
            if (i_mem_ready) begin
                r_out_valid      <= r_de_valid;
                r_out_result     <= r_de_valid ? w_result : 64'd0;
                r_out_store_data <= r_de_valid ? r_de_rs2 : 64'd0;
                r_out_rd         <= r_de_valid ? r_de_rd : 5'd0;
                r_out_rd_we      <= r_de_valid && r_de_rd_we;
                r_out_is_load    <= r_de_valid && (r_de_opc == c_OP_LOAD);
                r_out_is_store   <= r_de_valid && (r_de_opc == c_OP_STORE);
                r_out_f3         <= (r_de_valid && ((r_de_opc == c_OP_LOAD) ||
                                     (r_de_opc == c_OP_STORE))) ? r_de_f3 : 3'd0;
                if (w_redirect) begin
                    r_pc       <= w_target;
                    r_fd_valid <= 1'b0;
                    r_de_valid <= 1'b0;
                end else begin
                    r_de_valid <= w_issue;
                    r_de_rd_we <= w_id_rd_we;
                    r_de_f7b5  <= r_fd_instr[30];
                    r_de_opc   <= w_id_opc;
                    r_de_f3    <= r_fd_instr[14:12];
                    r_de_rd    <= w_id_rd;
                    r_de_pc    <= r_fd_pc;
                    r_de_rs1   <= w_id_rs1_val;
                    r_de_rs2   <= w_id_rs2_val;
                    r_de_imm   <= w_id_imm;
                    if (!w_hazard) begin
                        r_fd_valid <= 1'b1;
                        r_fd_instr <= w_if_instr;
                        r_fd_pc    <= r_pc;
                        r_pc       <= r_pc + 64'd4;
                    end
                end
            end
        end
    end

    assign o_ex_valid        = r_out_valid;
    assign o_ex_result       = r_out_result;
    assign o_ex_store_data   = r_out_store_data;
    assign o_ex_rd_addr      = r_out_rd;
    assign o_ex_rd_we        = r_out_rd_we;
    assign o_ex_is_load      = r_out_is_load;
    assign o_ex_is_store     = r_out_is_store;
    assign o_ex_funct3       = r_out_f3;
    assign o_ex_branch_taken = w_br_taken;
    assign o_ex_jump_taken   = w_jump;
    assign o_ex_target       = (w_br_taken || w_jump) ? w_target : 64'd0;
    assign o_illegal         = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_riv_front_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_riv_front_pipe
// Purpose  : directed self-checking bench for riv_front_pipe
// Revision : 1.0  initial release
// ============================================================================
module tb_riv_front_pipe;
    localparam int          IM_DEPTH = 256;
    localparam logic [31:0] c_NOP    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_wen;
    logic [7:0]  i_waddr;
    logic [31:0] i_wdata;
    logic        i_mem_ready;
    logic [4:0]  i_wb_wr_reg_addr;
    logic [63:0] i_wb_wr_reg_data;
    logic        i_wb_wr_reg_en;
    logic        o_ex_valid, o_ex_rd_we, o_ex_is_load, o_ex_is_store;
    logic        o_ex_branch_taken, o_ex_jump_taken, o_illegal;
    logic [63:0] o_ex_result, o_ex_store_data, o_ex_target;
    logic [4:0]  o_ex_rd_addr;
    logic [2:0]  o_ex_funct3;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    riv_front_pipe #(.IM_DEPTH(IM_DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_wen             (i_wen),
        .i_waddr           (i_waddr),
        .i_wdata           (i_wdata),
        .i_mem_ready       (i_mem_ready),
        .i_wb_wr_reg_addr  (i_wb_wr_reg_addr),
        .i_wb_wr_reg_data  (i_wb_wr_reg_data),
        .i_wb_wr_reg_en    (i_wb_wr_reg_en),
        .o_ex_valid        (o_ex_valid),
        .o_ex_result       (o_ex_result),
        .o_ex_store_data   (o_ex_store_data),
        .o_ex_rd_addr      (o_ex_rd_addr),
        .o_ex_rd_we        (o_ex_rd_we),
        .o_ex_is_load      (o_ex_is_load),
        .o_ex_is_store     (o_ex_is_store),
        .o_ex_funct3       (o_ex_funct3),
        .o_ex_branch_taken (o_ex_branch_taken),
        .o_ex_jump_taken   (o_ex_jump_taken),
        .o_ex_target       (o_ex_target),
        .o_illegal         (o_illegal)
    );

    // Advance one cycle; the bench then acts as a zero-latency write-back stage
    task automatic tick();
        @(posedge clk);
        #1;
        i_wb_wr_reg_en   = o_ex_valid && o_ex_rd_we;
        i_wb_wr_reg_addr = o_ex_rd_addr;
        i_wb_wr_reg_data = o_ex_result;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic imem_write(input int a, input logic [31:0] d, input logic [3:0] be);
        i_waddr = a[7:0];
        i_wdata = d;
        i_wen   = be;
        tick();
        i_wen   = 4'h0;
    endtask

    task automatic begin_test();
        rst         = 1'b1;
        i_mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) imem_write(i, c_NOP, 4'hF);
    endtask

    task automatic start_run();
        chk("rst_valid",  o_ex_valid, 0);
        chk("rst_result", o_ex_result, 0);
        chk("rst_rd_we",  o_ex_rd_we, 0);
        chk("rst_taken",  o_ex_branch_taken, 0);
        chk("rst_illegal", o_illegal, 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; i_wen = 4'h0; i_waddr = '0; i_wdata = '0; i_mem_ready = 1'b1;
        i_wb_wr_reg_en = 1'b0; i_wb_wr_reg_addr = '0; i_wb_wr_reg_data = '0;

        // ADDI x1,x0,5: visible at EX output on the third edge after release
        begin_test();
        imem_write(0, 32'h00500093, 4'hF);
        start_run();
        tick(); chk("s1_e1_valid", o_ex_valid, 0);
        tick(); chk("s1_e2_valid", o_ex_valid, 0);
        tick(); chk("s1_e3_valid", o_ex_valid, 1);
        chk("s1_rd", o_ex_rd_addr, 1);
        chk("s1_result", o_ex_result, 5);
        chk("s1_rd_we", o_ex_rd_we, 1);

        // ADDI x1,x0,-1 ; SRLI x2,x1,60 -> one stall bubble, then 0xF
        begin_test();
        imem_write(0, 32'hFFF00093, 4'hF);
        imem_write(1, 32'h03C0D113, 4'hF);
        start_run();
        tick(); tick(); tick();
        chk("s2_addi_rd", o_ex_rd_addr, 1);
        chk("s2_addi_result", o_ex_result, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(); chk("s2_stall_bubble", o_ex_valid, 0);
        tick(); chk("s2_srli_valid", o_ex_valid, 1);
        chk("s2_srli_rd", o_ex_rd_addr, 2);
        chk("s2_srli_result", o_ex_result, 64'hF);

        // BEQ x0,x0,+8 at 0x10; word at 0x14 must never reach EX output
        begin_test();
        imem_write(4, 32'h00000463, 4'hF);
        imem_write(5, 32'h07700393, 4'hF);
        imem_write(6, 32'h08800413, 4'hF);
        start_run();
        for (int k = 0; k < 6; k++) tick();
        chk("s3_br_taken", o_ex_branch_taken, 1);
        chk("s3_br_target", o_ex_target, 64'h18);
        chk("s3_no_jump", o_ex_jump_taken, 0);
        tick(); chk("s3_br_out_valid", o_ex_valid, 1);
        chk("s3_br_rd_we", o_ex_rd_we, 0);
        tick(); chk("s3_squash1", o_ex_valid, 0);
        tick(); chk("s3_squash2", o_ex_valid, 0);
        tick(); chk("s3_tgt_rd", o_ex_rd_addr, 8);
        chk("s3_tgt_result", o_ex_result, 64'h88);

        // ADDI x5,x0,0x100 ; JALR x1,x5,3 at PC 4
        begin_test();
        imem_write(0, 32'h10000293, 4'hF);
        imem_write(1, 32'h003280E7, 4'hF);
        start_run();
        tick(); tick(); tick(); tick();
        chk("s4_jump_taken", o_ex_jump_taken, 1);
        chk("s4_jalr_target", o_ex_target, 64'h102);
        tick(); chk("s4_jalr_result", o_ex_result, 64'h8);
        chk("s4_jalr_rd", o_ex_rd_addr, 1);
        chk("s4_jalr_rd_we", o_ex_rd_we, 1);

        // LUI x3 ; ADDIW x3,x3,-1 ; ADDI x4,x0,1 ; ADDW x5,x3,x4 ; then a 4-cycle freeze
        begin_test();
        imem_write(0, 32'h800001B7, 4'hF);
        imem_write(1, 32'hFFF1819B, 4'hF);
        imem_write(2, 32'h00100213, 4'hF);
        imem_write(3, 32'h004182BB, 4'hF);
        start_run();
        tick(); tick(); tick();
        chk("s5_lui", o_ex_result, 64'hFFFF_FFFF_8000_0000);
        tick(); tick();
        chk("s5_addiw", o_ex_result, 64'h0000_0000_7FFF_FFFF);
        tick(); chk("s5_addi", o_ex_result, 64'h1);
        tick(); chk("s5_stall_bubble", o_ex_valid, 0);
        tick(); chk("s5_addw_rd", o_ex_rd_addr, 5);
        chk("s5_addw", o_ex_result, 64'hFFFF_FFFF_8000_0000);
        i_mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hold_valid", o_ex_valid, 1);
            chk("hold_result", o_ex_result, 64'hFFFF_FFFF_8000_0000);
            chk("hold_rd", o_ex_rd_addr, 5);
        end
        i_mem_ready = 1'b1;
        tick(); chk("resume_valid", o_ex_valid, 1);
        chk("resume_rd_we", o_ex_rd_we, 0);

        // Unsupported opcode 0x7F followed by ADDI x6,x0,0x66
        begin_test();
        imem_write(0, 32'h0000007F, 4'hF);
        imem_write(1, 32'h06600313, 4'hF);
        start_run();
        tick(); chk("s6_e1_illegal", o_illegal, 0);
        tick(); chk("s6_illegal_pulse", o_illegal, 1);
        chk("s6_e2_valid", o_ex_valid, 0);
        tick(); chk("s6_illegal_end", o_illegal, 0);
        chk("s6_e3_valid", o_ex_valid, 0);
        tick(); chk("s6_next_rd", o_ex_rd_addr, 6);
        chk("s6_next_result", o_ex_result, 64'h66);

        // Byte-0-only writes: word0 turns rd 9 -> 8, word1 gets 0xAA (illegal opcode)
        begin_test();
        imem_write(0, 32'h01100493, 4'hF);
        imem_write(0, 32'h7FF00013, 4'b0001);
        imem_write(1, 32'h01100493, 4'hF);
        imem_write(1, 32'h555555AA, 4'b0001);
        imem_write(2, 32'h02200513, 4'hF);
        start_run();
        tick(); tick(); tick();
        chk("s7_w0_rd", o_ex_rd_addr, 8);
        chk("s7_w0_result", o_ex_result, 64'h11);
        chk("s7_w1_illegal", o_illegal, 1);
        tick(); chk("s7_bubble", o_ex_valid, 0);
        tick(); chk("s7_w2_rd", o_ex_rd_addr, 10);
        chk("s7_w2_result", o_ex_result, 64'h22);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
